// File: rtl/fixed_point_pkg.sv
// Shared Q-format constants for the ray-marcher fixed-point datapath (Q8.24).
package fixed_point_pkg;

  localparam int Q_WIDTH     = 32;
  localparam int Q_FRAC_BITS = 24;

  localparam logic [Q_WIDTH-1:0] FP_ONE  = 32'h0100_0000;
  localparam logic [Q_WIDTH-1:0] FP_HALF = 32'h0080_0000;
  localparam logic [Q_WIDTH-1:0] FP_TWO  = 32'h0200_0000;

endpackage

// File: rtl/sqrt_iter_step.sv
// One restoring digit-by-digit square-root iteration: consumes two radicand
// bits and yields the next root bit plus the updated partial remainder.
module sqrt_iter_step #(
  parameter int ITERS = 28
) (
  input  logic [ITERS+1:0] i_rem,
  input  logic [ITERS-1:0] i_root,
  input  logic [1:0]       i_bits,
  output logic [ITERS+1:0] o_rem,
  output logic [ITERS-1:0] o_root
);

  logic [ITERS+1:0] w_shift;
  logic [ITERS+1:0] w_trial;
  logic             w_ge;
  logic             w_unused;

  // A remainder fed back into a step is always below 2^ITERS, so its two top
  // bits are zero and dropping them in the shift loses nothing.
  assign w_unused = ^i_rem[ITERS+1:ITERS];

  assign w_shift = {i_rem[ITERS-1:0], i_bits};
  assign w_trial = {i_root, 2'b01};
  assign w_ge    = (w_shift >= w_trial);
  assign o_rem   = w_ge ? (w_shift - w_trial) : w_shift;
  assign o_root  = {i_root[ITERS-2:0], w_ge};

endmodule

// File: rtl/fixed_sqrt_iter.sv
// Iterative unsigned fixed-point square root, one result bit per clock.
// sqrt_out = floor(sqrt(x_in * 2^FRAC_BITS)) in the same Q format as x_in.
module fixed_sqrt_iter
  import fixed_point_pkg::*;
#(
  parameter int WIDTH     = Q_WIDTH,
  parameter int FRAC_BITS = Q_FRAC_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sqrt_out,
  output logic             out_exact,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       dbg_state
);

  localparam int RW    = WIDTH + FRAC_BITS;
  localparam int ITERS = RW / 2;
  localparam int CW    = $clog2(ITERS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshakes: a transfer happens on the rising edge where valid && ready.
  // in_ready is high only in IDLE; out_valid is held, with stable data,
  // until out_ready is seen high.
  state_t           r_state;
  logic [RW-1:0]    r_rad;
  logic [ITERS+1:0] r_rem;
  logic [ITERS-1:0] r_root;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sqrt;
  logic             r_exact;
  logic             r_valid;

  logic [ITERS+1:0] w_rem_nxt;
  logic [ITERS-1:0] w_root_nxt;

  sqrt_iter_step #(.ITERS(ITERS)) u_step (
    .i_rem  (r_rem),
    .i_root (r_root),
    .i_bits (r_rad[RW-1 -: 2]),
    .o_rem  (w_rem_nxt),
    .o_root (w_root_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rad   <= '0;
      r_rem   <= '0;
      r_root  <= '0;
      r_cnt   <= '0;
      r_sqrt  <= '0;
      r_exact <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_rad   <= {x_in, {FRAC_BITS{1'b0}}};
            r_rem   <= '0;
            r_root  <= '0;
            r_cnt   <= '0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_rad  <= {r_rad[RW-3:0], 2'b00};
          r_rem  <= w_rem_nxt;
          r_root <= w_root_nxt;
          r_cnt  <= r_cnt + 1'b1;
          // The result is published on the same edge as the last iteration.
          if (r_cnt == CW'(ITERS - 1)) begin
            r_sqrt  <= WIDTH'(w_root_nxt);
            r_exact <= (w_rem_nxt == '0);
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign sqrt_out  = r_sqrt;
  assign out_exact = r_exact;
  assign out_valid = r_valid;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fixed_sqrt_iter.sv
// Bench for fixed_sqrt_iter: directed boundary cases, backpressure, mid-run
// reset, and a random sweep against an integer square-root reference model.
module tb_fixed_sqrt_iter;

  logic        clk;
  logic        rst;
  logic [31:0] x_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] sqrt_out;
  logic        out_exact;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [32:0] exp_q[$];

  fixed_sqrt_iter dut (
    .clk       (clk),
    .rst       (rst),
    .x_in      (x_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sqrt_out  (sqrt_out),
    .out_exact (out_exact),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Largest y with y*y <= x*2^24, found by binary search over plain integers.
  function automatic logic [32:0] ref_sqrt(input logic [31:0] x);
    longint unsigned n, lo, hi, mid;
    n  = longint'(x) << 24;
    lo = 0;
    hi = (64'd1 << 28) - 1;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= n) lo = mid;
      else hi = mid - 1;
    end
    return {(lo * lo == n), lo[31:0]};
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic send(input logic [31:0] x, input logic [32:0] exp);
    int guard = 0;
    while (!in_ready && guard < 200) begin
      tick();
      guard++;
    end
    chk("in_ready_timeout", 64'(guard < 200), 64'd1);
    x_in     = x;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    x_in     = $urandom;
    exp_q.push_back(exp);
  endtask

  task automatic wait_out();
    int lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    chk("latency", 64'(lat), 64'd28);
  endtask

  task automatic recv(input int stall);
    logic [32:0] e;
    e = exp_q.pop_front();
    chk("sqrt_out", 64'(sqrt_out), 64'(e[31:0]));
    chk("out_exact", 64'(out_exact), 64'(e[32]));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      x_in     = $urandom;
      tick();
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_sqrt", 64'(sqrt_out), 64'(e[31:0]));
      chk("stall_exact", 64'(out_exact), 64'(e[32]));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_valid", 64'(out_valid), 64'd0);
    chk("post_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic op(input logic [31:0] x, input logic [32:0] exp, input int stall);
    send(x, exp);
    wait_out();
    recv(stall);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rx;
    int guard;
    rst       = 1'b1;
    x_in      = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sqrt", 64'(sqrt_out), 64'd0);
    chk("rst_exact", 64'(out_exact), 64'd0);
    rst = 1'b0;
    tick();

    // Directed values with hand-derived results.
    op(32'h0400_0000, {1'b1, 32'h0200_0000}, 0);
    op(32'h0200_0000, {1'b0, 32'h016A_09E6}, 0);
    op(32'h0000_0001, {1'b1, 32'h0000_1000}, 0);
    op(32'h0000_0000, {1'b1, 32'h0000_0000}, 0);
    op(32'hFFFF_FFFF, {1'b0, 32'h0FFF_FFFF}, 0);

    // Backpressure window with ignored in_valid pulses, then a fresh operand.
    op(32'h1900_0000, {1'b1, 32'h0500_0000}, 5);
    op(32'h0300_0000, ref_sqrt(32'h0300_0000), 0);

    // Reset during CALC discards the operation.
    send(32'h1234_5678, ref_sqrt(32'h1234_5678));
    repeat (10) tick();
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    tick();
    rst = 1'b0;
    void'(exp_q.pop_back());
    guard = 0;
    repeat (40) begin
      tick();
      if (out_valid) guard++;
    end
    chk("no_stale_result", 64'(guard), 64'd0);
    op(32'h0900_0000, {1'b1, 32'h0300_0000}, 0);

    // Random sweep with random output stalls.
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 3))
        0: rx = $urandom_range(0, 255);
        1: rx = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
        default: rx = $urandom;
      endcase
      op(rx, ref_sqrt(rx), $urandom_range(0, 3));
    end

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
